// File: rtl/bb_v0_arb_pkg.sv
// rtl/bb_v0_arb_pkg.sv - shared types and constants for the v0 sram arbiter
package bb_v0_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_INIT = 1'b1
  } arb_state_t;

  localparam int V0_WORDS = 16;
  localparam int VADDR_W  = 14;

  // Read tag: {valid, requester id (0=A, 1=B), is_read}
  localparam int TAG_W   = 3;
  localparam int TAG_VLD = 2;
  localparam int TAG_ID  = 1;
  localparam int TAG_RD  = 0;

  localparam logic [31:0] INIT_VAL_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/bb_v0_arb_rr2.sv
// rtl/bb_v0_arb_rr2.sv - 2-way round-robin picker with last-winner pointer
module bb_v0_arb_rr2 (
  input  logic       clk,
  input  logic       reset_l,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt
);

  // 1 = B was granted last, so A wins the first tie after reset
  logic r_last_b;

  // pick a winner; on a tie favour whoever was not granted last
  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = r_last_b ? 2'b01 : 2'b10;
        default: o_gnt = 2'b00;
      endcase
    end
  end

  // pointer follows the most recent winner
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_last_b <= 1'b1;
    end else if (|o_gnt) begin
      r_last_b <= o_gnt[1];
    end
  end

endmodule

// File: rtl/bb_v0_arb.sv
// rtl/bb_v0_arb.sv - v0 sram controller: A/B round-robin access plus init fill
module bb_v0_arb
  import bb_v0_arb_pkg::*;
#(
  parameter int          AW       = 4,
  parameter int          DW       = 32,
  parameter logic [DW-1:0] INIT_VAL = INIT_VAL_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_l,
  input  logic               a_req,
  input  logic               a_we,
  input  logic [VADDR_W-1:0] a_addr,
  input  logic [DW-1:0]      a_wdata,
  output logic               a_gnt,
  output logic               a_rvalid,
  output logic [DW-1:0]      a_rdata,
  input  logic               b_req,
  input  logic               b_we,
  input  logic [VADDR_W-1:0] b_addr,
  input  logic [DW-1:0]      b_wdata,
  output logic               b_gnt,
  output logic               b_rvalid,
  output logic [DW-1:0]      b_rdata,
  input  logic               init_start,
  output logic               init_busy,
  output logic               v_me,
  output logic               v_we,
  output logic [VADDR_W-1:0] v_addr,
  output logic [DW-1:0]      v_in,
  input  logic [DW-1:0]      v_out
);

  localparam logic [AW-1:0] LAST_WORD = AW'(V0_WORDS - 1);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [AW-1:0]      r_cnt;
  logic [AW-1:0]      w_cnt_nxt;
  logic               w_arb_en;
  logic [1:0]         w_req;
  logic [1:0]         w_gnt;

  logic               w_sel_b;
  logic               w_sel_we;
  logic [VADDR_W-1:0] w_sel_addr;
  logic [DW-1:0]      w_sel_wdata;

  logic               r_v_me;
  logic               r_v_we;
  logic [VADDR_W-1:0] r_v_addr;
  logic [DW-1:0]      r_v_in;

  logic [TAG_W-1:0]   r_tag0;
  logic [TAG_W-1:0]   r_tag1;
  logic               w_rsp_rd;
  logic               r_a_rvalid;
  logic               r_b_rvalid;
  logic [DW-1:0]      r_a_rdata;
  logic [DW-1:0]      r_b_rdata;

  assign w_req = {b_req, a_req};

  bb_v0_arb_rr2 u_rr2 (
    .clk     (clk),
    .reset_l (reset_l),
    .i_req   (w_req),
    .i_en    (w_arb_en),
    .o_gnt   (w_gnt)
  );

  assign a_gnt = w_gnt[0];
  assign b_gnt = w_gnt[1];

  // winner's command mux
  assign w_sel_b     = w_gnt[1];
  assign w_sel_we    = w_sel_b ? b_we    : a_we;
  assign w_sel_addr  = w_sel_b ? b_addr  : a_addr;
  assign w_sel_wdata = w_sel_b ? b_wdata : a_wdata;

  // next state: arbitration only in IDLE; INIT walks all words then returns
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_arb_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_arb_en = 1'b1;
        if (init_start) begin
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = '0;
        end
      end
      ST_INIT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == LAST_WORD) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // state and init counter registers
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // registered sram command: init writes take priority, else the granted access
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_v_me   <= 1'b0;
      r_v_we   <= 1'b0;
      r_v_addr <= '0;
      r_v_in   <= '0;
    end else if (r_state == ST_INIT) begin
      r_v_me   <= 1'b1;
      r_v_we   <= 1'b1;
      r_v_addr <= {{(VADDR_W-AW){1'b0}}, r_cnt};
      r_v_in   <= INIT_VAL;
    end else if (|w_gnt) begin
      r_v_me   <= 1'b1;
      r_v_we   <= w_sel_we;
      r_v_addr <= w_sel_addr;
      r_v_in   <= w_sel_wdata;
    end else begin
      r_v_me   <= 1'b0;
      r_v_we   <= 1'b0;
    end
  end

  // tag pipe tracks each grant through the macro's two-cycle read path
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_tag0 <= '0;
      r_tag1 <= '0;
    end else begin
      r_tag0 <= {(|w_gnt), w_sel_b, ~w_sel_we};
      r_tag1 <= r_tag0;
    end
  end

  assign w_rsp_rd = r_tag1[TAG_VLD] & r_tag1[TAG_RD];

  // route macro output to the owning port; rdata holds between pulses
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
      r_a_rdata  <= '0;
      r_b_rdata  <= '0;
    end else begin
      r_a_rvalid <= w_rsp_rd & ~r_tag1[TAG_ID];
      r_b_rvalid <= w_rsp_rd &  r_tag1[TAG_ID];
      if (w_rsp_rd & ~r_tag1[TAG_ID]) r_a_rdata <= v_out;
      if (w_rsp_rd &  r_tag1[TAG_ID]) r_b_rdata <= v_out;
    end
  end

  assign v_me      = r_v_me;
  assign v_we      = r_v_we;
  assign v_addr    = r_v_addr;
  assign v_in      = r_v_in;
  assign a_rvalid  = r_a_rvalid;
  assign a_rdata   = r_a_rdata;
  assign b_rvalid  = r_b_rvalid;
  assign b_rdata   = r_b_rdata;
  assign init_busy = (r_state == ST_INIT);

endmodule
